// File: rtl/uart_rx_fifo.sv
// UART receiver with a first-word-fall-through receive FIFO.
// The line is synchronized, frames are sampled at bit centres, and good
// frames are pushed into the FIFO. Error pulses report discarded frames.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          in,
   input  logic                          rd_en,
   output logic [DATA_BITS-1:0]          rd_data,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          busy,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overrun
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;
   localparam int HALF = CLKS_PER_BIT / 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t                 state;
   logic                   sync1, sync2, line_prev;
   logic [15:0]            tick_cnt;
   logic [3:0]             bit_cnt;
   logic [1:0]             stop_cnt;
   logic [DATA_BITS-1:0]   shreg;
   logic                   par_bit;
   logic                   stop_bad;

   logic                   bit_end;
   logic                   final_stop;
   logic                   stop_fail;
   logic                   par_fail;
   logic                   good;

   logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr, rd_ptr, rd_ptr_nxt;
   logic                   do_pop, do_push;
   logic [CW-1:0]          next_count, count_after_pop;

   // Two-flop synchronizer plus one history flop for falling-edge detection
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         line_prev <= 1'b1;
      end else begin
         sync1     <= in;
         sync2     <= sync1;
         line_prev <= sync2;
      end
   end

   // Frame completion and error classification at the final stop sample
   always_comb begin
      bit_end    = (tick_cnt == 16'(CLKS_PER_BIT - 1));
      final_stop = (state == ST_STOP) && bit_end && (stop_cnt == 2'(STOP_BITS - 1));
      stop_fail  = stop_bad | ~sync2;
      par_fail   = 1'b0;
      if (PARITY != 0)
         par_fail = ((^{shreg, par_bit}) != (PARITY == 1));
      good       = final_stop && !stop_fail && !par_fail;
   end

   // Receive FSM: bit timing, data shifting, stop/parity capture, busy flag
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         stop_cnt <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         stop_bad <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               tick_cnt <= '0;
               if (line_prev && !sync2) begin
                  state <= ST_START;
                  busy  <= 1'b1;
               end
            end
            ST_START: begin
               if (tick_cnt == 16'(HALF - 1)) begin
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
                  if (!sync2) begin
                     state <= ST_DATA;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  tick_cnt <= tick_cnt + 16'd1;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  tick_cnt <= '0;
                  shreg    <= {sync2, shreg[DATA_BITS-1:1]};
                  if (bit_cnt == 4'(DATA_BITS - 1)) begin
                     state    <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                     stop_cnt <= '0;
                     stop_bad <= 1'b0;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else begin
                  tick_cnt <= tick_cnt + 16'd1;
               end
            end
            ST_PARITY: begin
               if (bit_end) begin
                  tick_cnt <= '0;
                  par_bit  <= sync2;
                  state    <= ST_STOP;
               end else begin
                  tick_cnt <= tick_cnt + 16'd1;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  tick_cnt <= '0;
                  if (final_stop) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     stop_bad <= stop_bad | ~sync2;
                     stop_cnt <= stop_cnt + 2'd1;
                  end
               end else begin
                  tick_cnt <= tick_cnt + 16'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // FIFO control: a pop frees a slot for a simultaneous push when full
   always_comb begin
      do_pop          = rd_en & ~empty;
      do_push         = good & (~full | do_pop);
      count_after_pop = count - CW'(do_pop);
      next_count      = count_after_pop + CW'(do_push);
      rd_ptr_nxt      = rd_ptr + AW'(1);
   end

   // FIFO storage, registered status, head register and error pulses
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++)
            mem[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         empty      <= 1'b1;
         full       <= 1'b0;
         rd_data    <= '0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop)
            rd_ptr <= rd_ptr_nxt;
         count <= next_count;
         empty <= (next_count == '0);
         full  <= (next_count == CW'(FIFO_DEPTH));
         // Head register: new word lands directly when the queue drains to it
         if (do_push && count_after_pop == '0)
            rd_data <= shreg;
         else if (do_pop && count_after_pop != '0)
            rd_data <= mem[rd_ptr_nxt];
         frame_err  <= final_stop & stop_fail;
         parity_err <= final_stop & ~stop_fail & par_fail;
         overrun    <= good & full & ~do_pop;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: one instance without parity, one
// with even parity, driven by directed and random frames and compared
// against a queue-level model of what the receiver should hold.
module tb_uart_rx_fifo;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b1;
   logic [1:0] line    = 2'b11;
   logic [1:0] rd_en   = 2'b00;
   logic [1:0] empty, full, busy, ferr, perr, ovr;
   logic [7:0] rd_data [2];
   logic [2:0] count   [2];

   always #5 clock = ~clock;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut0 (
      .clock(clock), .reset_n(reset_n), .in(line[0]), .rd_en(rd_en[0]),
      .rd_data(rd_data[0]), .empty(empty[0]), .full(full[0]), .count(count[0]),
      .busy(busy[0]), .frame_err(ferr[0]), .parity_err(perr[0]), .overrun(ovr[0]));

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut1 (
      .clock(clock), .reset_n(reset_n), .in(line[1]), .rd_en(rd_en[1]),
      .rd_data(rd_data[1]), .empty(empty[1]), .full(full[1]), .count(count[1]),
      .busy(busy[1]), .frame_err(ferr[1]), .parity_err(perr[1]), .overrun(ovr[1]));

   int total = 0;
   int bad   = 0;

   // observed pulse totals and busy activity
   int seen_ferr [2] = '{0, 0};
   int seen_perr [2] = '{0, 0};
   int seen_ovr  [2] = '{0, 0};
   bit busy_seen [2] = '{0, 0};

   // reference model: FIFO contents (front at index 0) and expected pulse totals
   logic [7:0] mdat [2][DEPTH];
   int mcnt     [2] = '{0, 0};
   int exp_ferr [2] = '{0, 0};
   int exp_perr [2] = '{0, 0};
   int exp_ovr  [2] = '{0, 0};

   always @(negedge clock) begin
      for (int i = 0; i < 2; i++) begin
         seen_ferr[i] += int'(ferr[i]);
         seen_perr[i] += int'(perr[i]);
         seen_ovr[i]  += int'(ovr[i]);
         if (busy[i]) busy_seen[i] = 1'b1;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic check_state(input int w);
      chk($sformatf("d%0d_count", w), int'(count[w]), mcnt[w]);
      chk($sformatf("d%0d_empty", w), int'(empty[w]), int'(mcnt[w] == 0));
      chk($sformatf("d%0d_full", w), int'(full[w]), int'(mcnt[w] == DEPTH));
      if (mcnt[w] != 0)
         chk($sformatf("d%0d_rd_data", w), int'(rd_data[w]), int'(mdat[w][0]));
      chk($sformatf("d%0d_frame_err", w), seen_ferr[w], exp_ferr[w]);
      chk($sformatf("d%0d_parity_err", w), seen_perr[w], exp_perr[w]);
      chk($sformatf("d%0d_overrun", w), seen_ovr[w], exp_ovr[w]);
   endtask

   // what a correct receiver does with one complete frame
   task automatic model_frame(input int w, input logic [7:0] d, input bit bad_par, input bit bad_stop);
      if (bad_stop)
         exp_ferr[w]++;
      else if (w == 1 && bad_par)
         exp_perr[w]++;
      else if (mcnt[w] == DEPTH)
         exp_ovr[w]++;
      else begin
         mdat[w][mcnt[w]] = d;
         mcnt[w]++;
      end
   endtask

   task automatic send(input int w, input logic [7:0] d, input bit bad_par, input bit bad_stop);
      logic [10:0] bits;
      int n;
      bits    = '1;
      bits[0] = 1'b0;
      bits[8:1] = d;
      if (w == 1) begin
         bits[9]  = (^d) ^ bad_par;
         bits[10] = ~bad_stop;
         n = 11;
      end else begin
         bits[9] = ~bad_stop;
         n = 10;
      end
      for (int i = 0; i < n; i++) begin
         line[w] = bits[i];
         repeat (CPB) @(posedge clock);
      end
      line[w] = 1'b1;
      model_frame(w, d, bad_par, bad_stop);
      @(negedge clock);
      check_state(w);
   endtask

   task automatic idle_gap(input int w);
      line[w] = 1'b1;
      repeat (CPB) @(posedge clock);
   endtask

   task automatic pop(input int w);
      @(negedge clock);
      rd_en[w] = 1'b1;
      @(negedge clock);
      rd_en[w] = 1'b0;
      if (mcnt[w] > 0) begin
         for (int i = 0; i < DEPTH - 1; i++)
            mdat[w][i] = mdat[w][i+1];
         mcnt[w]--;
      end
      check_state(w);
   endtask

   task automatic reset_check();
      for (int w = 0; w < 2; w++) begin
         chk($sformatf("d%0d_rst_count", w), int'(count[w]), 0);
         chk($sformatf("d%0d_rst_empty", w), int'(empty[w]), 1);
         chk($sformatf("d%0d_rst_full", w), int'(full[w]), 0);
         chk($sformatf("d%0d_rst_rd_data", w), int'(rd_data[w]), 0);
         chk($sformatf("d%0d_rst_busy", w), int'(busy[w]), 0);
         mcnt[w] = 0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      int w;
      bit bs, bp;

      #2 reset_n = 1'b0;
      #1 reset_check();
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);
      check_state(0);
      check_state(1);

      // single good frame, no parity
      send(0, 8'hA5, 1'b0, 1'b0);
      pop(0);
      pop(0);                       // pop while empty is ignored

      // even parity: wrong parity bit, then a correct one
      send(1, 8'h07, 1'b1, 1'b0);
      send(1, 8'h07, 1'b0, 1'b0);
      pop(1);

      // low stop bit: frame error wins over a bad parity bit
      send(1, 8'h3C, 1'b1, 1'b1);
      idle_gap(1);
      send(0, 8'h3C, 1'b0, 1'b1);
      idle_gap(0);

      // fill to full back-to-back, fifth frame overruns
      for (int v = 1; v <= 5; v++)
         send(0, 8'(v), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++)
         pop(0);

      // short low glitch on an idle line
      busy_seen[0] = 1'b0;
      @(posedge clock);
      line[0] = 1'b0;
      repeat (4) @(posedge clock);
      line[0] = 1'b1;
      repeat (40) @(posedge clock);
      @(negedge clock);
      chk("glitch_busy_seen", int'(busy_seen[0]), 1);
      chk("glitch_busy_now", int'(busy[0]), 0);
      check_state(0);

      // random traffic on both receivers
      for (int it = 0; it < 40; it++) begin
         w  = int'($urandom_range(0, 1));
         d  = 8'($urandom);
         bs = ($urandom_range(0, 5) == 0);
         bp = ($urandom_range(0, 3) == 0);
         send(w, d, bp, bs);
         if (bs || $urandom_range(0, 2) == 0)
            idle_gap(w);
         for (int p = int'($urandom_range(0, 2)); p > 0; p--)
            pop(w);
      end

      // reset in the middle of data bit 3 of 0xFF
      @(posedge clock);
      line[0] = 1'b0;
      repeat (CPB) @(posedge clock);
      line[0] = 1'b1;
      repeat (3 * CPB + CPB / 2) @(posedge clock);
      @(negedge clock);
      chk("midframe_busy", int'(busy[0]), 1);
      reset_n = 1'b0;
      #1 reset_check();
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (2 * CPB) @(posedge clock);
      @(negedge clock);
      check_state(0);
      check_state(1);
      send(0, 8'h5A, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
